// File: rtl/msgdma_st_pkg.sv
// rtl/msgdma_st_pkg.sv - shared constants and helpers for the mSGDMA streaming width downsizer
package msgdma_st_pkg;

  // Default geometry: 64-bit timing adapter payload split into 32-bit beats.
  localparam int DEF_IN_WIDTH  = 64;
  localparam int DEF_OUT_WIDTH = 32;
  localparam int RATIO         = DEF_IN_WIDTH / DEF_OUT_WIDTH;
  localparam int IDX_W         = $clog2(RATIO);

  // Number of output beats per input word.
  function automatic int ratio_of(input int in_width, input int out_width);
    return in_width / out_width;
  endfunction

  // Slice-index width; at least one bit so the counter always exists.
  function automatic int idx_w_of(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Legal geometry: exact multiple, ratio a power of two and at least 2.
  function automatic bit widths_ok(input int in_width, input int out_width);
    int r;
    if (out_width <= 0) return 1'b0;
    if ((in_width % out_width) != 0) return 1'b0;
    r = in_width / out_width;
    if (r < 2) return 1'b0;
    return ((r & (r - 1)) == 0);
  endfunction

  // Maps the beat counter to the physical slice of the held word.
  function automatic int slice_sel(input int idx, input int ratio, input bit low_first);
    return low_first ? idx : (ratio - 1 - idx);
  endfunction

endpackage

// File: rtl/msgdma_st_downsizer.sv
// rtl/msgdma_st_downsizer.sv - Avalon-ST width downsizer, one held word emitted as RATIO narrow beats
module msgdma_st_downsizer
  import msgdma_st_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int LOW_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 in_ready,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 busy
);

  localparam int M_RATIO = ratio_of(IN_WIDTH, OUT_WIDTH);
  localparam int M_IDX_W = idx_w_of(M_RATIO);
  localparam logic [M_IDX_W-1:0] LAST_IDX = M_IDX_W'(M_RATIO - 1);

  if (!widths_ok(IN_WIDTH, OUT_WIDTH)) begin : g_bad_geometry
    $error("msgdma_st_downsizer: IN_WIDTH must be a power-of-2 multiple (>=2) of OUT_WIDTH");
  end

  logic [IN_WIDTH-1:0] buf_q;
  logic                full_q;
  logic [M_IDX_W-1:0]  idx_q;
  logic                last_slice;
  logic                accept;
  logic                out_hs;
  int                  sel;

  // Last slice is an explicit compare so the wrap never relies on counter overflow.
  assign last_slice = (idx_q == LAST_IDX);

  // A new word may enter when empty, or when the final beat leaves this cycle.
  assign in_ready  = !full_q || (last_slice && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_hs    = full_q && out_ready;
  assign out_valid = full_q;
  assign busy      = full_q;

  // Word buffer, occupancy flag and beat counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q  <= '0;
      full_q <= 1'b0;
      idx_q  <= '0;
    end else if (accept) begin
      buf_q  <= in_data;
      full_q <= 1'b1;
      idx_q  <= '0;
    end else if (out_hs) begin
      if (last_slice) begin
        full_q <= 1'b0;
        idx_q  <= '0;
      end else begin
        idx_q  <= idx_q + 1'b1;
      end
    end
  end

  assign sel = slice_sel(int'(idx_q), M_RATIO, LOW_FIRST != 0);

  // Register-fed slice mux; out-of-range selects fall back to zero.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < M_RATIO; i++) begin
      if (i == sel) out_data = buf_q[i*OUT_WIDTH +: OUT_WIDTH];
    end
  end

endmodule

// File: tb/tb_msgdma_st_downsizer.sv
// tb/tb_msgdma_st_downsizer.sv - self-checking bench for msgdma_st_downsizer in both slice orders
module tb_msgdma_st_downsizer;

  localparam int IW = 64;
  localparam int OW = 32;
  localparam int R  = IW / OW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic [IW-1:0] in_data;
  logic          out_ready;

  logic          ir_lo, ov_lo, busy_lo;
  logic [OW-1:0] od_lo;
  logic          ir_hi, ov_hi, busy_hi;
  logic [OW-1:0] od_hi;

  int checks   = 0;
  int failures = 0;

  // Expected beats still to be delivered by each DUT, oldest first.
  logic [OW-1:0] q_lo[$];
  logic [OW-1:0] q_hi[$];

  always #5 clk = ~clk;

  msgdma_st_downsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LOW_FIRST(1)) dut_lo (
    .clk(clk), .reset_n(reset_n), .in_ready(ir_lo), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(ov_lo), .out_data(od_lo), .busy(busy_lo)
  );

  msgdma_st_downsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LOW_FIRST(0)) dut_hi (
    .clk(clk), .reset_n(reset_n), .in_ready(ir_hi), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(ov_hi), .out_data(od_hi), .busy(busy_hi)
  );

  task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the beat queues, then advance the model.
  task automatic step(output bit acc);
    bit exp_ir;
    bit hs;
    logic [IW-1:0] w;
    #1;
    exp_ir = (q_lo.size() == 0) || (q_lo.size() == 1 && out_ready);
    chk("in_ready_lo", ir_lo, exp_ir);
    chk("in_ready_hi", ir_hi, exp_ir);
    chk("out_valid_lo", ov_lo, q_lo.size() != 0);
    chk("out_valid_hi", ov_hi, q_hi.size() != 0);
    chk("busy_lo", busy_lo, q_lo.size() != 0);
    chk("busy_hi", busy_hi, q_hi.size() != 0);
    if (q_lo.size() != 0) chk("out_data_lo", od_lo, q_lo[0]);
    if (q_hi.size() != 0) chk("out_data_hi", od_hi, q_hi[0]);
    if (!reset_n) begin
      chk("rst_data_lo", od_lo, 0);
      chk("rst_data_hi", od_hi, 0);
    end
    acc = reset_n && in_valid && exp_ir;
    hs  = reset_n && (q_lo.size() != 0) && out_ready;
    w   = in_data;
    @(posedge clk);
    if (hs) begin
      void'(q_lo.pop_front());
      void'(q_hi.pop_front());
    end
    if (acc) begin
      for (int k = 0; k < R; k++) begin
        q_lo.push_back(OW'(w >> (OW * k)));
        q_hi.push_back(OW'(w >> (OW * (R - 1 - k))));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bit acc;
    int words;

    // Reset held with input offered: nothing is accepted, outputs at reset values.
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hDEAD_BEEF_CAFE_F00D;
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(acc);
    chk("rst_no_accept", acc, 1'b0);

    // Single word, known pattern, sink always ready.
    reset_n  = 1'b1;
    in_data  = 64'h1122334455667788;
    in_valid = 1'b1;
    step(acc);
    chk("first_accept", acc, 1'b1);
    in_valid = 1'b0;
    chk("first_beat_lo", od_lo, 32'h55667788);
    chk("first_beat_hi", od_hi, 32'h11223344);
    for (int i = 0; i < 3; i++) step(acc);

    // Eight back-to-back words, sink always ready: no bubbles.
    in_valid = 1'b1;
    in_data  = {$urandom(), $urandom()};
    words    = 0;
    for (int i = 0; i < 20; i++) begin
      if (words == 8) in_valid = 1'b0;
      step(acc);
      if (acc) begin
        words++;
        in_data = {$urandom(), $urandom()};
      end
    end
    chk("stream_words", words, 8);

    // Backpressure on the second slice for five cycles.
    in_valid = 1'b1;
    in_data  = 64'h1122334455667788;
    step(acc);
    chk("bp_accept", acc, 1'b1);
    in_data = 64'hAAAA_BBBB_CCCC_DDDD;
    step(acc);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(acc);
      chk("bp_hold_lo", od_lo, 32'h11223344);
      chk("bp_no_accept", acc, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step(acc);

    // Randomized traffic on both handshakes.
    in_data = {$urandom(), $urandom()};
    for (int i = 0; i < 300; i++) begin
      in_valid  = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      step(acc);
      if (acc) in_data = {$urandom(), $urandom()};
    end

    // Drain, then reset in the middle of a word.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step(acc);
    in_valid = 1'b1;
    in_data  = 64'h0123456789ABCDEF;
    step(acc);
    in_valid = 1'b0;
    step(acc);
    reset_n = 1'b0;
    q_lo.delete();
    q_hi.delete();
    #1;
    chk("async_rst_valid_lo", ov_lo, 1'b0);
    chk("async_rst_valid_hi", ov_hi, 1'b0);
    step(acc);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step(acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
